regfile_dump_reader: RTL and testbench

Debug-side reader for the 32×32 core register file. On a start request it walks a contiguous register range through one register-file read port, snapshots each value, and streams it out as `(address, data)` beats on a valid/ready interface toward the debug/trace path. It sits beside the decode stage, sharing read port 2 through an external mux whose select is `busy`. It never writes the register file.

---
 rtl/regfile_dump_reader.sv | 162 ++++++++++++++++
 tb/tb_regfile_dump_reader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Debug dump of a register range through one read port as (addr, data) beats; REGFILE_DUMP_CKSUM_EN adds an XOR checksum beat.
// Latency: first beat valid 2 cycles after start, 2 cycles per beat with dump_ready high.
// Backpressure: a presented beat is held stable until dump_ready; the walk stalls meanwhile.
module regfile_dump_reader #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] first_addr,
   input  logic [ADDR_WIDTH-1:0] last_addr,
   output logic [ADDR_WIDTH-1:0] read_address,
   input  logic [DATA_WIDTH-1:0] read_data,
   output logic                  dump_valid,
   input  logic                  dump_ready,
   output logic [ADDR_WIDTH-1:0] dump_addr,
   output logic [DATA_WIDTH-1:0] dump_data,
   output logic                  dump_last,
   output logic                  dump_cksum,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

`ifdef REGFILE_DUMP_CKSUM_EN
   typedef enum logic [1:0] {IDLE, READ, HOLD, CKSUM} state_t;
`else
   typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;
`endif

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] cur, last;
   logic                  accept, reject, capture, advance, finish;
`ifdef REGFILE_DUMP_CKSUM_EN
   logic                  to_cksum;
   logic [DATA_WIDTH-1:0] cksum;
   logic                  cksum_beat;
`endif

   assign busy         = (state != IDLE);
   assign read_address = (state == IDLE) ? '0 : cur;
`ifdef REGFILE_DUMP_CKSUM_EN
   assign dump_valid   = (state == HOLD) || (state == CKSUM);
   assign dump_cksum   = cksum_beat;
`else
   assign dump_valid   = (state == HOLD);
   assign dump_cksum   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      reject    = 1'b0;
      capture   = 1'b0;
      advance   = 1'b0;
      finish    = 1'b0;
`ifdef REGFILE_DUMP_CKSUM_EN
      to_cksum  = 1'b0;
`endif
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (first_addr <= last_addr) begin
                     accept    = 1'b1;
                     state_nxt = READ;
                  end else begin
                     reject = 1'b1;
                  end
               end
            end
            READ: begin
               capture   = 1'b1;
               state_nxt = HOLD;
            end
            HOLD: begin
               if (dump_ready) begin
                  if (cur != last) begin
                     advance   = 1'b1;
                     state_nxt = READ;
                  end else begin
`ifdef REGFILE_DUMP_CKSUM_EN
                     to_cksum  = 1'b1;
                     state_nxt = CKSUM;
`else
                     finish    = 1'b1;
                     state_nxt = IDLE;
`endif
                  end
               end
            end
`ifdef REGFILE_DUMP_CKSUM_EN
            CKSUM: begin
               if (dump_ready) begin
                  finish    = 1'b1;
                  state_nxt = IDLE;
               end
            end
`endif
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Beat registers are only loaded in READ/CKSUM entry, so a stalled beat is a true snapshot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur       <= '0;
         last      <= '0;
         dump_addr <= '0;
         dump_data <= '0;
         dump_last <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
`ifdef REGFILE_DUMP_CKSUM_EN
         cksum      <= '0;
         cksum_beat <= 1'b0;
`endif
      end else begin
         done  <= finish;
         error <= reject;
         if (accept) begin
            cur  <= first_addr;
            last <= last_addr;
`ifdef REGFILE_DUMP_CKSUM_EN
            cksum <= '0;
`endif
         end
         if (advance) cur <= cur + ADDR_WIDTH'(1);
         if (capture) begin
            dump_addr <= cur;
            dump_data <= read_data;
`ifdef REGFILE_DUMP_CKSUM_EN
            dump_last <= 1'b0;
            cksum     <= cksum ^ read_data;
`else
            dump_last <= (cur == last);
`endif
         end
`ifdef REGFILE_DUMP_CKSUM_EN
         if (to_cksum) begin
            dump_addr  <= '0;
            dump_data  <= cksum;
            dump_last  <= 1'b1;
            cksum_beat <= 1'b1;
         end
         if (abort || finish) cksum_beat <= 1'b0;
`endif
         if (abort || finish) dump_last <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: table of ranges plus hold, abort and async-reset sequences.
`timescale 1ns/1ps
module tb_regfile_dump_reader;
   localparam int AW = 5;
   localparam int DW = 32;
`ifdef REGFILE_DUMP_CKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] first_addr = '0;
   logic [AW-1:0] last_addr = '0;
   logic [AW-1:0] read_address;
   logic [DW-1:0] read_data;
   logic          dump_valid;
   logic          dump_ready = 1'b1;
   logic [AW-1:0] dump_addr;
   logic [DW-1:0] dump_data;
   logic          dump_last;
   logic          dump_cksum;
   logic          busy;
   logic          done;
   logic          error;

   logic [DW-1:0] regs [32];
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   assign read_data = regs[read_address];

   regfile_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .first_addr(first_addr), .last_addr(last_addr),
      .read_address(read_address), .read_data(read_data),
      .dump_valid(dump_valid), .dump_ready(dump_ready),
      .dump_addr(dump_addr), .dump_data(dump_data),
      .dump_last(dump_last), .dump_cksum(dump_cksum),
      .busy(busy), .done(done), .error(error)
   );

   typedef struct {
      int first;
      int last;
      int beats;
      int done_cyc;
      int err_cyc;
   } vec_t;
   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic kick(input logic [AW-1:0] f, input logic [AW-1:0] l);
      first_addr = f;
      last_addr  = l;
      start      = 1'b1;
      step();
      start      = 1'b0;
      cyc        = 1;
   endtask

   // done_cyc in the table is for the plain build; the checksum beat adds one cycle.
   task automatic run_range(input int f, input int l, input int nb, input int dc, input int ec);
      int beats, done_at, err_at, busy_cnt, cks_seen, exp_done;
      logic [DW-1:0] x;
      beats = 0; done_at = 0; err_at = 0; busy_cnt = 0; cks_seen = 0; x = '0;
      exp_done = (dc == 0) ? 0 : dc + CK;
      dump_ready = 1'b1;
      kick(AW'(f), AW'(l));
      for (int i = 0; i < 80; i++) begin
         if (error && err_at == 0) err_at = cyc;
         if (done && done_at == 0) done_at = cyc;
         if (busy) busy_cnt++;
         if (dump_valid && dump_ready) begin
            if (dump_cksum) begin
               chk("cksum_cycle", cyc, 2 * nb + 1);
               chk("cksum_data", dump_data, x);
               chk("cksum_addr", 32'(dump_addr), 0);
               chk("cksum_last", 32'(dump_last), 1);
               cks_seen++;
            end else begin
               chk("beat_cycle", cyc, 2 * beats + 2);
               chk("beat_addr", 32'(dump_addr), f + beats);
               chk("beat_data", dump_data, regs[AW'(f + beats)]);
               chk("beat_last", 32'(dump_last), 32'(CK == 0 && f + beats == l));
               x ^= regs[AW'(f + beats)];
               beats++;
            end
         end
         if (done_at != 0 && cyc > done_at) break;
         if (exp_done == 0 && cyc > 4) break;
         step();
      end
      chk("beat_count", beats, nb);
      chk("cksum_count", cks_seen, (nb > 0) ? CK : 0);
      chk("done_cycle", done_at, exp_done);
      chk("error_cycle", err_at, ec);
      chk("busy_cycles", busy_cnt, (exp_done == 0) ? 0 : exp_done - 1);
      chk("busy_after", 32'(busy), 0);
   endtask

   initial begin
      int found;
      int seen_done;
      for (int i = 0; i < 32; i++) regs[i] = i * 32'h01010101;
      vecs[0] = '{0, 31, 32, 65, 0};
      vecs[1] = '{5, 5, 1, 3, 0};
      vecs[2] = '{9, 3, 0, 0, 1};
      vecs[3] = '{30, 31, 2, 5, 0};
      vecs[4] = '{0, 0, 1, 3, 0};
      vecs[5] = '{10, 12, 3, 7, 0};
      vecs[6] = '{31, 31, 1, 3, 0};

      repeat (2) @(posedge clk);
      #1;
      chk("reset_data", dump_data, 0);
      chk("reset_ctrl", 32'({dump_valid, busy, done, error, dump_last, dump_cksum, read_address, dump_addr}), 0);
      rst = 1'b1;
      step();

      for (int v = 0; v < 7; v++)
         run_range(vecs[v].first, vecs[v].last, vecs[v].beats, vecs[v].done_cyc, vecs[v].err_cyc);

      // Single beat stalled 4 cycles; register changes underneath must not leak into it.
      dump_ready = 1'b0;
      kick(5, 5);
      step();
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", 32'(dump_valid), 1);
         chk("hold_addr", 32'(dump_addr), 5);
         chk("hold_data", dump_data, 32'h05050505);
         chk("hold_last", 32'(dump_last), 32'(CK == 0));
         if (i == 0) regs[5] = 32'hdeadbeef;
         if (i == 4) dump_ready = 1'b1;
         step();
      end
`ifdef REGFILE_DUMP_CKSUM_EN
      chk("hold_cksum_beat", 32'({dump_valid, dump_cksum, dump_last}), 32'b111);
      chk("hold_cksum_data", dump_data, 32'h05050505);
      step();
`endif
      chk("hold_done", 32'(done), 1);
      chk("hold_busy", 32'(busy), 0);
      regs[5] = 32'h05050505;
      step();
      chk("hold_done_pulse", 32'(done), 0);

      // Abort while addr 10 is stalled.
      dump_ready = 1'b1;
      kick(0, 31);
      found = 0;
      for (int i = 0; i < 60 && found == 0; i++) begin
         if (dump_valid && dump_addr == 10) found = 1;
         else step();
      end
      chk("abort_reach", found, 1);
      dump_ready = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_valid", 32'(dump_valid), 0);
      chk("abort_flags", 32'({busy, dump_last, dump_cksum, done}), 0);
      seen_done = 0;
      for (int i = 0; i < 3; i++) begin
         if (done) seen_done = 1;
         step();
      end
      chk("abort_no_done", seen_done, 0);
      run_range(1, 2, 2, 5, 0);

      // Checksum range with distinct bits per register.
      regs[1] = 32'd1; regs[2] = 32'd2; regs[3] = 32'd4;
      run_range(1, 3, 3, 7, 0);
      for (int i = 1; i < 4; i++) regs[i] = i * 32'h01010101;

      // Asynchronous reset in the HOLD of addr 2.
      dump_ready = 1'b1;
      kick(0, 31);
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         if (dump_valid && dump_addr == 2) found = 1;
         else step();
      end
      chk("arst_reach", found, 1);
      dump_ready = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("arst_data", dump_data, 0);
      chk("arst_ctrl", 32'({dump_valid, busy, done, error, dump_last, dump_cksum, read_address, dump_addr}), 0);
      #1 rst = 1'b1;
      step();
      chk("arst_idle", 32'({dump_valid, busy}), 0);
      run_range(3, 4, 2, 5, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
